// File: rtl/message_scheduler.sv
// message_scheduler
//   Arbitrates the four-letter message area between the persistent game-state
//   message, transient event messages and blinking of result messages.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   state_msg    persistent message {L3,L2,L1,L0}, 6-bit letter codes
//   result_flag  high while the game sits in a WIN/LOSE/TIE result state
//   evt_req      event request, held until evt_ack
//   evt_code     event letter codes, stable while evt_req is high
//   evt_ack      one-cycle pulse, event accepted
//   msg_out      letter codes to decoders hex3..hex0
//   busy         high while an event or blink is in progress
module message_scheduler #(
  parameter int HOLD_CYCLES  = 25_000_000,
  parameter int BLINK_CYCLES = 12_500_000,
  parameter int BLINK_COUNT  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] state_msg,
  input  logic        result_flag,
  input  logic        evt_req,
  input  logic [23:0] evt_code,
  output logic        evt_ack,
  output logic [23:0] msg_out,
  output logic        busy
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int PW = $clog2(BLINK_CYCLES + 1);
  localparam int CW = $clog2(BLINK_COUNT + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(BLINK_CYCLES - 1);
  localparam logic [CW-1:0] PAIR_LAST  = CW'(BLINK_COUNT - 1);
  localparam logic [23:0]   BLANK      = {4{6'h3F}};

  typedef enum logic [1:0] {IDLE, EVENT, BLINK_ON, BLINK_OFF} state_e;

  state_e        state_q;
  logic [HW-1:0] hold_q;
  logic [PW-1:0] phase_q;
  logic [CW-1:0] pair_q;
  logic          done_q;
  logic          ack_q;
  logic          busy_q;
  logic [23:0]   msg_q;

  assign evt_ack = ack_q;
  assign msg_out = msg_q;
  assign busy    = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      phase_q <= '0;
      pair_q  <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      msg_q   <= BLANK;
    end else begin
      ack_q <= 1'b0;
      // A finished blink stays suppressed only for the current result episode.
      if (!result_flag) done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (evt_req) begin
            state_q <= EVENT;
            msg_q   <= evt_code;
            ack_q   <= 1'b1;
            hold_q  <= '0;
            busy_q  <= 1'b1;
          end else if (result_flag && !done_q) begin
            state_q <= BLINK_ON;
            phase_q <= '0;
            pair_q  <= '0;
            msg_q   <= state_msg;
            busy_q  <= 1'b1;
          end else begin
            msg_q  <= state_msg;
            busy_q <= 1'b0;
          end
        end
        EVENT: begin
          if (hold_q == HOLD_LAST) begin
            if (evt_req) begin
              // back-to-back: no state_msg cycle between the two events
              msg_q  <= evt_code;
              ack_q  <= 1'b1;
              hold_q <= '0;
            end else begin
              state_q <= IDLE;
              msg_q   <= state_msg;
              busy_q  <= 1'b0;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        BLINK_ON: begin
          if (!result_flag) begin
            state_q <= IDLE;
            msg_q   <= state_msg;
            busy_q  <= 1'b0;
          end else if (phase_q == PHASE_LAST) begin
            state_q <= BLINK_OFF;
            phase_q <= '0;
            msg_q   <= BLANK;
          end else begin
            phase_q <= phase_q + 1'b1;
            msg_q   <= state_msg;
          end
        end
        BLINK_OFF: begin
          if (!result_flag) begin
            state_q <= IDLE;
            msg_q   <= state_msg;
            busy_q  <= 1'b0;
          end else if (phase_q == PHASE_LAST) begin
            phase_q <= '0;
            pair_q  <= pair_q + 1'b1;
            msg_q   <= state_msg;
            if (pair_q == PAIR_LAST) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= BLINK_ON;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_message_scheduler.sv
// tb_message_scheduler
//   Directed scenarios followed by randomized traffic, with a behavioural
//   model compared against the DUT after every clock edge.
module tb_message_scheduler;

  localparam int HOLD  = 4;
  localparam int BLINK = 2;
  localparam int COUNT = 2;
  localparam logic [23:0] BLANK = {4{6'h3F}};
  localparam logic [23:0] PLAY  = {6'd25, 6'd21, 6'd10, 6'd34};
  localparam logic [23:0] BUST  = {6'd11, 6'd30, 6'd28, 6'd29};
  localparam logic [23:0] HIT   = {6'd17, 6'd18, 6'd29, 6'h3F};
  localparam logic [23:0] WIN   = {6'h3F, 6'd32, 6'd18, 6'd23};
  localparam logic [23:0] DEAL  = {6'd13, 6'd14, 6'd10, 6'd21};

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] state_msg;
  logic        result_flag;
  logic        evt_req;
  logic [23:0] evt_code;
  logic        evt_ack;
  logic [23:0] msg_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  message_scheduler #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK), .BLINK_COUNT(COUNT)) dut (
    .clk(clk), .reset(reset), .state_msg(state_msg), .result_flag(result_flag),
    .evt_req(evt_req), .evt_code(evt_code), .evt_ack(evt_ack),
    .msg_out(msg_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = showing state, 1 = event, 2 = blinking.
  // Event is a countdown of remaining display cycles; blink is a running
  // tick index whose ON/OFF phase is (tick / BLINK) parity.
  int          m_mode = 0;
  int          m_left = 0;
  int          m_tick = 0;
  bit          m_done = 0;
  logic [23:0] m_msg  = BLANK;
  logic        m_ack  = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_msg = BLANK; m_ack = 0; m_done = 0;
    end else begin
      m_ack = 0;
      case (m_mode)
        0: begin
          if (evt_req) begin
            m_mode = 1; m_left = HOLD - 1; m_msg = evt_code; m_ack = 1;
          end else if (result_flag && !m_done) begin
            m_mode = 2; m_tick = 0; m_msg = state_msg;
          end else m_msg = state_msg;
        end
        1: begin
          if (m_left == 0) begin
            if (evt_req) begin
              m_left = HOLD - 1; m_msg = evt_code; m_ack = 1;
            end else begin
              m_mode = 0; m_msg = state_msg;
            end
          end else m_left--;
        end
        default: begin
          if (!result_flag) begin
            m_mode = 0; m_msg = state_msg;
          end else begin
            m_tick++;
            if (m_tick == 2 * BLINK * COUNT) begin
              m_done = 1; m_mode = 0; m_msg = state_msg;
            end else m_msg = ((m_tick / BLINK) % 2 == 0) ? state_msg : BLANK;
          end
        end
      endcase
      if (!result_flag) m_done = 0;
    end
    #1;
    chk("model_msg", {8'h0, msg_out}, {8'h0, m_msg});
    chk("model_ack", {31'h0, evt_ack}, {31'h0, m_ack});
    chk("model_busy", {31'h0, busy}, {31'h0, (m_mode != 0)});
  end

  // Inputs change 2 time units after the edge; checks happen at +1.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  localparam logic [23:0] BLINK_SEQ [8] = '{WIN, WIN, BLANK, BLANK, WIN, WIN, BLANK, BLANK};

  initial begin
    reset = 1; state_msg = PLAY; result_flag = 0; evt_req = 0; evt_code = '0;

    // reset
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_msg", {8'h0, msg_out}, {8'h0, BLANK});
      chk("rst_ack", {31'h0, evt_ack}, 32'h0);
    end
    reset = 0;
    tick(); tick();
    chk("post_rst_msg", {8'h0, msg_out}, {8'h0, PLAY});

    // single event
    evt_req = 1; evt_code = BUST;
    tick();
    chk("ev_ack", {31'h0, evt_ack}, 32'h1);
    chk("ev_msg0", {8'h0, msg_out}, {8'h0, BUST});
    evt_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ev_hold_msg", {8'h0, msg_out}, {8'h0, BUST});
      chk("ev_hold_ack", {31'h0, evt_ack}, 32'h0);
      chk("ev_busy", {31'h0, busy}, 32'h1);
    end
    tick();
    chk("ev_end_msg", {8'h0, msg_out}, {8'h0, PLAY});
    chk("ev_end_busy", {31'h0, busy}, 32'h0);
    tick();

    // back-to-back events
    evt_req = 1; evt_code = BUST;
    tick();
    evt_req = 0;
    tick();
    evt_req = 1; evt_code = HIT;
    tick(); tick();
    chk("b2b_last_bust", {8'h0, msg_out}, {8'h0, BUST});
    tick();
    chk("b2b_ack", {31'h0, evt_ack}, 32'h1);
    chk("b2b_msg", {8'h0, msg_out}, {8'h0, HIT});
    evt_req = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_end", {8'h0, msg_out}, {8'h0, PLAY});

    // result blink
    state_msg = WIN; result_flag = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("blink_seq", {8'h0, msg_out}, {8'h0, BLINK_SEQ[i]});
      chk("blink_busy", {31'h0, busy}, 32'h1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("blink_steady", {8'h0, msg_out}, {8'h0, WIN});
      chk("blink_nobusy", {31'h0, busy}, 32'h0);
    end
    result_flag = 0;
    tick();

    // abort in 3rd blink cycle
    result_flag = 1;
    tick(); tick(); tick();
    chk("abort_blank", {8'h0, msg_out}, {8'h0, BLANK});
    result_flag = 0;
    tick();
    chk("abort_msg", {8'h0, msg_out}, {8'h0, WIN});
    chk("abort_busy", {31'h0, busy}, 32'h0);
    tick();

    // event deferred by blink
    result_flag = 1;
    tick();
    evt_req = 1; evt_code = DEAL;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("defer_noack", {31'h0, evt_ack}, 32'h0);
    end
    tick();
    chk("defer_ack", {31'h0, evt_ack}, 32'h1);
    chk("defer_msg", {8'h0, msg_out}, {8'h0, DEAL});
    evt_req = 0;
    for (int i = 0; i < 5; i++) tick();
    result_flag = 0;
    tick();

    // reset mid-event
    evt_req = 1; evt_code = BUST;
    tick();
    evt_req = 0;
    tick();
    evt_req = 1; evt_code = HIT; reset = 1;
    tick();
    chk("rst_ev_msg", {8'h0, msg_out}, {8'h0, BLANK});
    chk("rst_ev_ack", {31'h0, evt_ack}, 32'h0);
    chk("rst_ev_busy", {31'h0, busy}, 32'h0);
    evt_req = 0; reset = 0;
    tick();

    // randomized traffic, requester follows the req/ack handshake
    for (int n = 0; n < 4000; n++) begin
      if (evt_req && evt_ack) evt_req = 0;
      else if (!evt_req && $urandom_range(0, 5) == 0) begin
        evt_req = 1; evt_code = 24'($urandom);
      end
      if ($urandom_range(0, 15) == 0) result_flag = ~result_flag;
      if ($urandom_range(0, 7) == 0) state_msg = 24'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/message_scheduler.md
Name: message_scheduler

Overview:
- Sequences the four-letter message area (hex3..hex0 letter codes) between the persistent game-state message, transient event messages (e.g. HIT, BUST, DEAL), and blinking of result messages.
- Sits between the game FSM / event sources and the four seven-segment letter decoders.
- Replaces direct state-to-letter mapping with a timed, arbitrated schedule.

Parameters:
- HOLD_CYCLES, 25_000_000, cycles an event message stays on display; legal range ≥ 2.
- BLINK_CYCLES, 12_500_000, length of each blink ON or OFF phase in cycles; legal range ≥ 1.
- BLINK_COUNT, 6, number of ON/OFF pairs shown before a result message goes steady; legal range ≥ 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- state_msg  in  24  persistent message; letter codes {L3,L2,L1,L0}, 6 bits each, L3 in [23:18]
- result_flag  in  1  high while the game is in a WIN, LOSE or TIE result state
- evt_req  in  1  event message request; held high until evt_ack is seen
- evt_code  in  24  event message letter codes; stable while evt_req is high
- evt_ack  out  1  one-cycle pulse; event accepted
- msg_out  out  24  letter codes to decoders hex3..hex0
- busy  out  1  high in EVENT, BLINK_ON and BLINK_OFF

Behaviour:
- All outputs are registered. BLANK letter code = 6'h3F.
- Reset values:
  - state = IDLE
  - msg_out = {4{6'h3F}}
  - evt_ack = 0, busy = 0
  - hold and blink counters = 0
  - blink_done = 0
- Reset mid-operation aborts any event or blink immediately. No ack is issued for a pending request.

States and transitions (evaluated at each clk edge; priority is in the order listed):
- IDLE:
  - evt_req=1 → go to EVENT. Set msg_out←evt_code, evt_ack←1, hold_cnt←0.
  - Otherwise, result_flag=1 and blink_done=0 → go to BLINK_ON. Set phase_cnt←0, pair_cnt←0, msg_out←state_msg.
  - Otherwise stay in IDLE and set msg_out←state_msg (1-cycle latency).
- EVENT:
  - evt_ack is forced 0 after its single cycle.
  - hold_cnt increments each cycle. msg_out holds evt_code for exactly HOLD_CYCLES cycles.
  - At hold_cnt = HOLD_CYCLES-1:
    - if evt_req=1, accept back-to-back: load new evt_code, pulse evt_ack, clear hold_cnt, stay in EVENT;
    - otherwise go to IDLE.
- BLINK_ON:
  - msg_out tracks state_msg.
  - After BLINK_CYCLES cycles → BLINK_OFF, msg_out←BLANK.
- BLINK_OFF:
  - msg_out = BLANK.
  - After BLINK_CYCLES cycles, pair_cnt increments.
    - pair_cnt reaches BLINK_COUNT → set blink_done←1, go to IDLE (steady display).
    - Otherwise → BLINK_ON.

Arbitration and boundary conditions:
- Events are not accepted during BLINK_ON or BLINK_OFF; evt_req waits until the blink completes or aborts.
- result_flag falling in BLINK_ON or BLINK_OFF aborts to IDLE on the next edge, with msg_out←state_msg.
- blink_done clears whenever result_flag=0.
- result_flag rising during EVENT: the blink starts only after the event finishes, and only if result_flag is still high.
- Counters are sized $clog2(max+1). Counters are cleared on state entry and never wrap inside a phase.

Test Plan:
1. Use HOLD=4, BLINK=2, COUNT=2 for all scenarios.
2. Reset: assert reset 2 cycles with state_msg=PLAY → msg_out=3F3F3F3F and evt_ack=0 during reset; msg_out=PLAY on the second edge after release.
3. Single event: evt_req with BUST in IDLE → evt_ack high exactly 1 cycle; msg_out=BUST for 4 cycles; busy=1 for 4 cycles; then msg_out=state_msg.
4. Back-to-back: second request (HIT) already pending at event end → second evt_ack one cycle after the last BUST cycle; no state_msg cycle between BUST and HIT.
5. Result blink: state_msg=_WIN, result_flag=1 → msg_out sequence WIN,WIN,BLK,BLK,WIN,WIN,BLK,BLK, then steady WIN; busy drops; no re-blink while result_flag stays high.
6. Abort and deferral:
   - result_flag drops in the 3rd blink cycle → msg_out=state_msg on the next edge.
   - evt_req raised mid-blink → evt_ack only after the blink completes.
   - reset mid-EVENT → msg_out=BLANK and no ack.
